bitrev_engine: RTL and testbench
================================

# bitrev_engine

Parametrised, register-mapped bit-reversal accelerator with input and output FIFOs, selectable reversal granularity, sticky status flags and an interrupt. Software pushes operands through DIN, starts the engine, then pops results through DOUT. The engine streams words through the FIFOs until the input FIFO is empty. It sits on the peripheral register bus and succeeds the single-word start/done/din/dout control block.

## Interface
- DATA_W, 32: operand width. Must be 8, 16 or 32. Bus writes truncate to DATA_W; bus reads zero-extend to 32 bits.
- DEPTH, 4: entries per FIFO. Must be a power of two, ≥2. Count fields are $clog2(DEPTH+1) bits wide.
- clk_i  in  1  single clock.
- rst_ni  in  1  synchronous, active-low reset.
- reg_valid_i  in  1  register access request.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  4  byte offset: 0x0 CTRL, 0x4 STATUS, 0x8 DIN, 0xC DOUT.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data, combinational in the access cycle. 0 when there is no read.
- reg_ready_o  out  1  tied to 1. Every access completes in one cycle.
- busy_o  out  1  FSM is in RUN.
- irq_o  out  1  DONE & IRQ_EN, registered.

## Operation
- CTRL bit fields:
  - [0] START: write-1 pulse, reads 0.
  - [1] CLEAR: write-1 pulse, reads 0.
  - [3:2] MODE: reverse the order of groups of 1/2/4/8 bits (MODE 0/1/2/3).
  - [4] IRQ_EN.
- STATUS bit fields:
  - [0] DONE: W1C.
  - [1] BUSY.
  - [2] IN_FULL.
  - [3] OUT_EMPTY.
  - [4] OVERFLOW: W1C.
  - [5] UNDERFLOW: W1C.
  - [15:8] IN_COUNT.
  - [23:16] OUT_COUNT.
- Writes to STATUS bits other than the W1C bits are ignored.
- DIN write: pushes into the input FIFO. If the FIFO is full, the word is dropped and OVERFLOW is set.
- DOUT read: pops the output FIFO at the closing edge. If the FIFO is empty, returns 0 and sets UNDERFLOW.
- Reads of CTRL/STATUS/DIN and writes to DOUT have no side effects. DIN reads 0.
- FSM has two states, IDLE and RUN:
  - IDLE → RUN on a START write. MODE is latched into an internal register at that edge.
  - RUN, input FIFO non-empty, output FIFO not full: pop one word, reverse it with the latched MODE, push the result to the output FIFO in the same edge.
  - RUN, output FIFO full: stall. No pop, no push.
  - RUN, input FIFO empty: → IDLE and set DONE.
  - Words pushed to DIN during RUN are processed in the same run.
- START in RUN: ignored.
- START in IDLE with an empty input FIFO: DONE is set after one RUN cycle.
- CLEAR, in any state: empties both FIFOs and forces IDLE. DONE is not set; flags are unchanged.
- CLEAR and START in the same write: CLEAR wins and START is discarded.
- MODE writes during RUN update CTRL only. The latched MODE is unchanged until the next START.
- Flag set and W1C in the same cycle: set wins.
- Input pop and DIN push in the same cycle: both take effect, IN_COUNT is unchanged. The same rule applies to the output FIFO for push and DOUT pop.
- Full-FIFO pop and push in the same cycle: the push is accepted.

## Timing
- Reset values: CTRL 0, all flags 0, both FIFOs empty, state IDLE, busy_o 0, irq_o 0, reg_rdata_o 0.
- START accepted at edge E0: BUSY=1 from after E0.
- With no stalls, word k enters the output FIFO at edge E0+k+1.
- DONE=1 and BUSY=0 after edge E0+N+1. irq_o rises in the same cycle if IRQ_EN=1.
- Each output stall cycle delays completion by one cycle.
- Read-after-write: STATUS reflects a DIN write in the following cycle.
- Reset mid-run: synchronous return to the reset values at the next edge. Partial data is discarded.

## Structure
- Package bitrev_engine_pkg holds:
  - register offsets;
  - CTRL/STATUS bit-position constants;
  - mode enum: MODE_BIT, MODE_PAIR, MODE_NIBBLE, MODE_BYTE;
  - FSM state enum;
  - function reverse_groups(data, mode) parametrised by DATA_W.
- Sub-module bitrev_fifo: synchronous FIFO with parameters DATA_W and DEPTH, ports push/pop/full/empty/count, instantiated twice.
- Top level holds the register decode, the FSM and the flag logic.

## Test plan
- Mode and value checks, DATA_W=32 (MODE write, DIN write, START, then DOUT read):
  - MODE 0, DIN 0x00000001 → DOUT 0x80000000.
  - MODE 1, 0x0000001B → 0xE4000000.
  - MODE 2, 0x12345678 → 0x87654321.
  - MODE 3, 0x11223344 → 0x44332211.
- Burst, DEPTH=4:
  - Push 4 words, then a 5th → OVERFLOW=1, IN_COUNT=4.
  - START → DONE after exactly 5 cycles.
  - 4 DOUT reads return the words in order.
  - A 5th DOUT read → 0 and UNDERFLOW=1.
- Output backpressure: with the output FIFO full, push 2 more words and START → BUSY stays 1. Each DOUT pop lets one word through. DONE follows the final pop.
- Interrupt and W1C: IRQ_EN=1, run 1 word → irq_o=1. Write 1 to STATUS[0] → DONE=0 and irq_o=0 next cycle. A W1C coincident with a new DONE set leaves DONE=1.
- CLEAR during RUN with 3 words queued → BUSY=0, IN_COUNT=OUT_COUNT=0, DONE=0 next cycle.
- Reset: rst_ni low for one edge mid-run → all outputs and STATUS return to reset values.

Source files
------------

// File: rtl/bitrev_engine_pkg.sv
// bitrev_engine_pkg: register map, bit positions, types and the group-reversal helper
// Shared by bitrev_engine and bitrev_fifo; no ports.
package bitrev_engine_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_DIN    = 4'h8;
    localparam logic [3:0] ADDR_DOUT   = 4'hC;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_MODE   = 2;
    localparam int CTRL_IRQ_EN = 4;

    localparam int ST_DONE      = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_IN_FULL   = 2;
    localparam int ST_OUT_EMPTY = 3;
    localparam int ST_OVERFLOW  = 4;
    localparam int ST_UNDERFLOW = 5;
    localparam int ST_IN_COUNT  = 8;
    localparam int ST_OUT_COUNT = 16;

    typedef enum logic [1:0] {
        MODE_BIT    = 2'd0,
        MODE_PAIR   = 2'd1,
        MODE_NIBBLE = 2'd2,
        MODE_BYTE   = 2'd3
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Reverses the order of 2**mode-bit groups inside the low data_w bits.
    // Bit b of group k lands at bit b of group (data_w/g - 1 - k).
    function automatic logic [31:0] reverse_groups(input logic [31:0] data, input mode_e mode,
                                                   input int data_w);
        int g;
        logic [31:0] r;
        g = 1 << int'(mode);
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < data_w)
                r = r | (((data >> i) & 32'd1) << (data_w - g - g * (i / g) + i % g));
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_fifo.sv
// bitrev_fifo: synchronous FIFO with occupancy count
// clk_i/rst_ni    clock, synchronous active-low reset
// clr_i           empties the FIFO
// push_i/wdata_i  write request and data; accepted when not full or when popping
// pop_i/rdata_o   read request and head word (rdata_o is valid while not empty)
// full_o/empty_o/count_o  occupancy
module bitrev_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same edge frees the slot, so a full FIFO still takes the push.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/bitrev_engine.sv
// bitrev_engine: register-mapped streaming bit-reversal accelerator with in/out FIFOs
// clk_i/rst_ni                      clock, synchronous active-low reset
// reg_valid_i/reg_write_i           bus access request, 1 = write
// reg_addr_i/reg_wdata_i            byte offset (CTRL/STATUS/DIN/DOUT) and write data
// reg_rdata_o/reg_ready_o           combinational read data, always ready
// busy_o                            engine running
// irq_o                             registered DONE & IRQ_EN
module bitrev_engine
    import bitrev_engine_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [3:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    output logic        reg_ready_o,
    output logic        busy_o,
    output logic        irq_o
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, run_mode_q, run_mode_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d, ovf_q, ovf_d, udf_q, udf_d, irq_q;
    logic              wr, rd, ctrl_wr, status_wr, din_wr, dout_rd;
    logic              start, clear, step, finish;
    logic              in_full, in_empty, out_full, out_empty;
    logic [CW-1:0]     in_count, out_count;
    logic [DATA_W-1:0] in_word, out_word, rev_word;
    logic [31:0]       rev_full, status, ctrl;
    logic              unused_ok;

    assign wr        = reg_valid_i & reg_write_i;
    assign rd        = reg_valid_i & ~reg_write_i;
    assign ctrl_wr   = wr && reg_addr_i == ADDR_CTRL;
    assign status_wr = wr && reg_addr_i == ADDR_STATUS;
    assign din_wr    = wr && reg_addr_i == ADDR_DIN;
    assign dout_rd   = rd && reg_addr_i == ADDR_DOUT;
    // CLEAR overrides a START carried by the same write.
    assign clear     = ctrl_wr & reg_wdata_i[CTRL_CLEAR];
    assign start     = ctrl_wr & reg_wdata_i[CTRL_START] & ~reg_wdata_i[CTRL_CLEAR];
    // The engine only moves a word when the output FIFO has room at the start of the cycle.
    assign step      = state_q == S_RUN && !in_empty && !out_full;
    assign finish    = state_q == S_RUN && in_empty && !clear;

    assign rev_full  = reverse_groups(32'(in_word), run_mode_q, DATA_W);
    assign rev_word  = rev_full[DATA_W-1:0];
    assign unused_ok = ^{reg_wdata_i, rev_full};

    bitrev_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clear),
        .push_i  (din_wr),
        .pop_i   (step),
        .wdata_i (reg_wdata_i[DATA_W-1:0]),
        .rdata_o (in_word),
        .full_o  (in_full),
        .empty_o (in_empty),
        .count_o (in_count)
    );

    bitrev_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clear),
        .push_i  (step),
        .pop_i   (dout_rd),
        .wdata_i (rev_word),
        .rdata_o (out_word),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_count)
    );

    always_comb begin
        state_d    = state_q;
        run_mode_d = run_mode_q;
        if (clear) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE && start) begin
            state_d    = S_RUN;
            run_mode_d = mode_e'(reg_wdata_i[CTRL_MODE +: 2]);
        end else if (finish) begin
            state_d = S_IDLE;
        end
    end

    // Sticky flags: a set in the same cycle as its W1C wins.
    assign done_d   = finish | (done_q & ~(status_wr & reg_wdata_i[ST_DONE]));
    assign ovf_d    = (din_wr & in_full & ~step) | (ovf_q & ~(status_wr & reg_wdata_i[ST_OVERFLOW]));
    assign udf_d    = (dout_rd & out_empty) | (udf_q & ~(status_wr & reg_wdata_i[ST_UNDERFLOW]));
    assign mode_d   = ctrl_wr ? mode_e'(reg_wdata_i[CTRL_MODE +: 2]) : mode_q;
    assign irq_en_d = ctrl_wr ? reg_wdata_i[CTRL_IRQ_EN] : irq_en_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_BIT;
            run_mode_q <= MODE_BIT;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            run_mode_q <= run_mode_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            irq_q      <= done_d & irq_en_d;
        end
    end

    always_comb begin
        status                        = '0;
        status[ST_DONE]               = done_q;
        status[ST_BUSY]               = state_q == S_RUN;
        status[ST_IN_FULL]            = in_full;
        status[ST_OUT_EMPTY]          = out_empty;
        status[ST_OVERFLOW]           = ovf_q;
        status[ST_UNDERFLOW]          = udf_q;
        status[ST_IN_COUNT +: 8]      = 8'(in_count);
        status[ST_OUT_COUNT +: 8]     = 8'(out_count);
        ctrl                          = '0;
        ctrl[CTRL_MODE +: 2]          = mode_q;
        ctrl[CTRL_IRQ_EN]             = irq_en_q;
        reg_rdata_o                   = '0;
        if (rd)
            reg_rdata_o = reg_addr_i == ADDR_CTRL   ? ctrl :
                          reg_addr_i == ADDR_STATUS ? status :
                          reg_addr_i == ADDR_DOUT && !out_empty ? 32'(out_word) : '0;
    end

    assign reg_ready_o = 1'b1;
    assign busy_o      = state_q == S_RUN;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_bitrev_engine.sv
// tb_bitrev_engine: queue-based reference model, per-cycle compare, directed and random stimulus
module tb_bitrev_engine;

    localparam int DW = 32;
    localparam int D  = 4;
    localparam logic [3:0] A_CTRL = 4'h0, A_STAT = 4'h4, A_DIN = 4'h8, A_DOUT = 4'hC;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, write = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready, busy, irq;

    int n_cmp = 0, n_err = 0;

    logic [31:0] inq[$], outq[$];
    bit          m_valid = 1'b0;
    bit          m_run, m_done, m_ovf, m_udf, m_irq, m_irqen;
    logic [1:0]  m_mode, m_lat;

    always #5 clk = ~clk;

    bitrev_engine #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reg_valid_i (valid),
        .reg_write_i (write),
        .reg_addr_i  (addr),
        .reg_wdata_i (wdata),
        .reg_rdata_o (rdata),
        .reg_ready_o (ready),
        .busy_o      (busy),
        .irq_o       (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Group reversal from the definition: group j moves to group n-1-j.
    function automatic logic [31:0] mrev(input logic [31:0] d, input logic [1:0] m);
        int g, n;
        logic [31:0] r, mask;
        g    = 1 << m;
        n    = DW / g;
        mask = (32'd1 << g) - 32'd1;
        r    = 32'd0;
        for (int j = 0; j < n; j++) r |= ((d >> (j * g)) & mask) << ((n - 1 - j) * g);
        return r;
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!valid || write) return 32'd0;
        case (addr)
            A_CTRL:  return {27'd0, m_irqen, m_mode, 2'b00};
            A_STAT:  return {8'd0, 8'(outq.size()), 8'(inq.size()), 2'b00, m_udf, m_ovf,
                             outq.size() == 0, inq.size() == D, m_run, m_done};
            A_DOUT:  return outq.size() != 0 ? outq[0] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: applies one bus access and one engine step per rising edge.
    initial begin
        bit w, r, cw, clr, st, sw, stp, fin, ovf_set, udf_set;
        logic [31:0] v;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                inq.delete();
                outq.delete();
                {m_run, m_done, m_ovf, m_udf, m_irq, m_irqen} = '0;
                m_mode  = 2'd0;
                m_lat   = 2'd0;
                m_valid = 1'b1;
            end else begin
                w       = valid & write;
                r       = valid & ~write;
                cw      = w && addr == A_CTRL;
                sw      = w && addr == A_STAT;
                clr     = cw && wdata[1];
                st      = cw && wdata[0] && !clr;
                stp     = m_run && inq.size() != 0 && outq.size() < D;
                fin     = m_run && inq.size() == 0 && !clr;
                ovf_set = 1'b0;
                udf_set = 1'b0;
                if (r && addr == A_DOUT) begin
                    if (outq.size() == 0) udf_set = 1'b1;
                    else void'(outq.pop_front());
                end
                if (stp) begin
                    v = inq.pop_front();
                    outq.push_back(mrev(v, m_lat));
                end
                if (w && addr == A_DIN) begin
                    if (inq.size() < D) inq.push_back(wdata);
                    else ovf_set = 1'b1;
                end
                if (clr) begin
                    inq.delete();
                    outq.delete();
                    m_run = 1'b0;
                end else if (!m_run && st) begin
                    m_run = 1'b1;
                    m_lat = wdata[3:2];
                end else if (fin) begin
                    m_run = 1'b0;
                end
                if (cw) begin
                    m_mode  = wdata[3:2];
                    m_irqen = wdata[4];
                end
                m_done = fin || (m_done && !(sw && wdata[0]));
                m_ovf  = ovf_set || (m_ovf && !(sw && wdata[4]));
                m_udf  = udf_set || (m_udf && !(sw && wdata[5]));
                m_irq  = m_done && m_irqen;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("rdata", rdata, exp_rd());
            chk("busy", 32'(busy), 32'(m_run));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("ready", 32'(ready), 32'd1);
        end
    end

    task automatic acc(input bit w, input logic [3:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        valid = 1'b1;
        write = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid = 1'b0;
            write = 1'b0;
        end
    endtask

    task automatic rd_lit(input string nm, input logic [3:0] a, input logic [31:0] exp);
        acc(1'b0, a, 32'd0);
        @(negedge clk);
        chk(nm, rdata, exp);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid = 1'b0;
        write = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] mv_din[4] = '{32'h00000001, 32'h0000001B, 32'h12345678, 32'h11223344};
    logic [31:0] mv_exp[4] = '{32'h80000000, 32'hE4000000, 32'h87654321, 32'h44332211};
    logic [31:0] bw[4]     = '{32'h11223344, 32'hAABBCCDD, 32'h01020304, 32'hDEADBEEF};
    logic [31:0] bx[4]     = '{32'h44332211, 32'hDDCCBBAA, 32'h04030201, 32'hEFBEADDE};
    logic [31:0] dr[4]     = '{32'hC0000000, 32'h20000000, 32'hF0000000, 32'h08000000};

    initial begin
        int k;
        logic [31:0] r;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        rd_lit("reset_status", A_STAT, 32'h00000008);
        rd_lit("reset_ctrl", A_CTRL, 32'h00000000);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        for (int m = 0; m < 4; m++) begin
            acc(1'b1, A_CTRL, 32'(m << 2));
            acc(1'b1, A_DIN, mv_din[m]);
            acc(1'b1, A_CTRL, 32'(m << 2) | 32'd1);
            idle(3);
            rd_lit("mode_dout", A_DOUT, mv_exp[m]);
        end

        acc(1'b1, A_CTRL, 32'h2);
        acc(1'b1, A_STAT, 32'h31);
        for (int i = 0; i < 4; i++) acc(1'b1, A_DIN, bw[i]);
        acc(1'b1, A_DIN, 32'h55555555);
        rd_lit("burst_overflow_status", A_STAT, 32'h0000041C);
        acc(1'b1, A_CTRL, 32'h0D);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            @(negedge clk);
            chk("burst_busy", 32'(busy), 32'(i < 5));
        end
        rd_lit("burst_done_status", A_STAT, 32'h00040011);
        for (int i = 0; i < 4; i++) rd_lit("burst_dout", A_DOUT, bx[i]);
        rd_lit("underflow_dout", A_DOUT, 32'h0);
        rd_lit("underflow_status", A_STAT, 32'h00000039);

        acc(1'b1, A_STAT, 32'h31);
        for (int i = 1; i <= 4; i++) acc(1'b1, A_DIN, 32'(i));
        acc(1'b1, A_CTRL, 32'h1);
        idle(6);
        acc(1'b1, A_DIN, 32'h0000000F);
        acc(1'b1, A_DIN, 32'h00000010);
        acc(1'b1, A_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            @(negedge clk);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        rd_lit("stall_pop1", A_DOUT, 32'h80000000);
        idle(2);
        rd_lit("stall_pop2", A_DOUT, 32'h40000000);
        idle(3);
        @(negedge clk);
        chk("stall_done_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) rd_lit("stall_drain", A_DOUT, dr[i]);

        acc(1'b1, A_CTRL, 32'h2);
        acc(1'b1, A_STAT, 32'h31);
        acc(1'b1, A_CTRL, 32'h10);
        acc(1'b1, A_DIN, 32'h000000A5);
        acc(1'b1, A_CTRL, 32'h11);
        idle(3);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        acc(1'b1, A_STAT, 32'h1);
        idle(1);
        @(negedge clk);
        chk("irq_w1c", 32'(irq), 32'd0);
        acc(1'b1, A_DIN, 32'h0000005A);
        acc(1'b1, A_CTRL, 32'h11);
        idle(1);
        acc(1'b1, A_STAT, 32'h1);
        idle(1);
        @(negedge clk);
        chk("irq_set_beats_w1c", 32'(irq), 32'd1);
        rd_lit("set_beats_w1c_status", A_STAT, 32'h00020001);

        acc(1'b1, A_CTRL, 32'h2);
        acc(1'b1, A_STAT, 32'h31);
        for (int i = 0; i < 3; i++) acc(1'b1, A_DIN, 32'h100 + 32'(i));
        acc(1'b1, A_CTRL, 32'h1);
        acc(1'b1, A_CTRL, 32'h2);
        idle(1);
        @(negedge clk);
        chk("clear_busy", 32'(busy), 32'd0);
        rd_lit("clear_status", A_STAT, 32'h00000008);

        acc(1'b1, A_CTRL, 32'h10);
        for (int i = 0; i < 3; i++) acc(1'b1, A_DIN, 32'h200 + 32'(i));
        acc(1'b1, A_CTRL, 32'h1D);
        idle(2);
        pulse_reset();
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        rd_lit("rst_mid_status", A_STAT, 32'h00000008);
        rd_lit("rst_mid_ctrl", A_CTRL, 32'h00000000);

        for (int c = 0; c < 3000; c++) begin
            k = int'($urandom_range(0, 99));
            r = $urandom();
            if ($urandom_range(0, 999) == 0) pulse_reset();
            else if (k < 25) acc(1'b1, A_DIN, $urandom());
            else if (k < 45) acc(1'b0, A_DOUT, 32'd0);
            else if (k < 55) acc(1'b0, A_STAT, 32'd0);
            else if (k < 60) acc(1'b0, A_CTRL, 32'd0);
            else if (k < 68) acc(1'b1, A_CTRL, {27'd0, r[4], r[3:2], r[10:8] == 3'd0, r[0] | r[1]});
            else if (k < 74) acc(1'b1, A_STAT, r);
            else if (k < 78) acc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), r);
            else idle(1);
        end
        idle(2);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
